// File: rtl/sprite_sched_pkg.sv
// Shared types and geometry constants for the per-scanline sprite scheduler.
package sprite_sched_pkg;
  localparam int SPR_H   = 8;
  localparam int COORD_W = 8;
  localparam int ROW_W   = $clog2(SPR_H);
  localparam int BMP_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_REQ,
    SCAN_CHK,
    FETCH_REQ,
    FETCH_WR,
    DONE
  } state_t;
endpackage

// File: rtl/sprite_line_scheduler_row_hit.sv
// Vertical intersection test: does a sprite starting at y cover line ly, and which row.
module sprite_row_hit
  import sprite_sched_pkg::*;
(
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] ly,
  output logic               hit,
  output logic [ROW_W-1:0]   row
);
  logic [COORD_W:0] d;

  // Borrow bit set means ly is above the sprite; no wrap past line 255.
  assign d   = {1'b0, ly} - {1'b0, y};
  assign hit = !d[COORD_W] && (d < (COORD_W + 1)'(SPR_H));
  assign row = d[ROW_W-1:0];
endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans the sprite table during hblank, fills up to NUM_SLOTS render slots and publishes them atomically.
// Optional overflow-line counter enabled by defining SPRITE_SCHED_OVF_STATS_EN.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int NUM_SLOTS   = 2,
  parameter int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         line_start,
  input  logic [COORD_W-1:0]           next_ly,
  output logic                         tbl_rd_en,
  output logic [IDX_W-1:0]             tbl_rd_addr,
  input  logic [COORD_W-1:0]           tbl_rd_x,
  input  logic [COORD_W-1:0]           tbl_rd_y,
  output logic                         bmp_rd_en,
  output logic [IDX_W+ROW_W-1:0]       bmp_rd_addr,
  input  logic [BMP_W-1:0]             bmp_rd_data,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic [COORD_W*NUM_SLOTS-1:0] slot_x,
  output logic [BMP_W*NUM_SLOTS-1:0]   slot_row,
  output logic [IDX_W*NUM_SLOTS-1:0]   slot_id,
  output logic                         commit,
  output logic                         busy,
  output logic                         overflow,
  output logic                         late,
  output logic [7:0]                   ovf_count
);
  localparam int USED_W = $clog2(NUM_SLOTS + 1);

  state_t                       state, state_nxt;
  logic [COORD_W-1:0]           ly_r;
  logic [IDX_W-1:0]             idx;
  logic [USED_W-1:0]            used;
  logic [COORD_W-1:0]           x_r;
  logic [ROW_W-1:0]             row_r;
  logic [NUM_SLOTS-1:0]         pend_valid;
  logic [COORD_W*NUM_SLOTS-1:0] pend_x;
  logic [BMP_W*NUM_SLOTS-1:0]   pend_row;
  logic [IDX_W*NUM_SLOTS-1:0]   pend_id;
  logic                         pend_ovf;
  logic                         hit;
  logic [ROW_W-1:0]             hit_row;
  logic                         last, full, start, commit_go;

  sprite_row_hit u_row_hit (
    .y   (tbl_rd_y),
    .ly  (ly_r),
    .hit (hit),
    .row (hit_row)
  );

  assign last      = (idx == IDX_W'(NUM_SPRITES - 1));
  assign full      = (used == USED_W'(NUM_SLOTS));
  assign start     = enable && line_start;
  // A new line_start during DONE aborts that line, so it must not publish.
  assign commit_go = (state == DONE) && enable && !line_start;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (line_start) begin
      state_nxt = SCAN_REQ;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        SCAN_REQ:  state_nxt = SCAN_CHK;
        SCAN_CHK:  if (hit)       state_nxt = full ? DONE : FETCH_REQ;
                   else if (last) state_nxt = DONE;
                   else           state_nxt = SCAN_REQ;
        FETCH_REQ: state_nxt = FETCH_WR;
        FETCH_WR:  state_nxt = last ? DONE : SCAN_REQ;
        DONE:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tbl_rd_en = 1'b0;
    bmp_rd_en = 1'b0;
    busy      = (state != IDLE);
    case (state)
      SCAN_REQ:  tbl_rd_en = 1'b1;
      FETCH_REQ: bmp_rd_en = 1'b1;
      default:   ;
    endcase
  end

  assign tbl_rd_addr = idx;
  assign bmp_rd_addr = {idx, row_r};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ly_r       <= '0;
      idx        <= '0;
      used       <= '0;
      x_r        <= '0;
      row_r      <= '0;
      pend_valid <= '0;
      pend_x     <= '0;
      pend_row   <= '0;
      pend_id    <= '0;
      pend_ovf   <= 1'b0;
    end else if (start) begin
      ly_r       <= next_ly;
      idx        <= '0;
      used       <= '0;
      pend_valid <= '0;
      pend_x     <= '0;
      pend_row   <= '0;
      pend_id    <= '0;
      pend_ovf   <= 1'b0;
    end else begin
      case (state)
        SCAN_CHK: begin
          if (hit) begin
            x_r   <= tbl_rd_x;
            row_r <= hit_row;
            if (full) pend_ovf <= 1'b1;
          end else if (!last) begin
            idx <= idx + IDX_W'(1);
          end
        end
        FETCH_WR: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (used == USED_W'(k)) begin
              pend_valid[k]              <= 1'b1;
              pend_x[COORD_W*k +: COORD_W] <= x_r;
              pend_row[BMP_W*k +: BMP_W]   <= bmp_rd_data;
              pend_id[IDX_W*k +: IDX_W]    <= idx;
            end
          end
          used <= used + USED_W'(1);
          if (!last) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Active set: replaced in one cycle, wiped while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      slot_valid <= '0;
      slot_x     <= '0;
      slot_row   <= '0;
      slot_id    <= '0;
      overflow   <= 1'b0;
      commit     <= 1'b0;
    end else begin
      commit <= commit_go;
      if (commit_go) begin
        slot_valid <= pend_valid;
        slot_x     <= pend_x;
        slot_row   <= pend_row;
        slot_id    <= pend_id;
        overflow   <= pend_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable)                    late <= 1'b0;
    else if (line_start && (state != IDLE))   late <= 1'b1;
  end

`ifdef SPRITE_SCHED_OVF_STATS_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                                          ovf_cnt <= '0;
    else if (commit_go && pend_ovf && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler with a behavioural sprite table and commit scoreboard.
module tb_sprite_line_scheduler;
  localparam int NS  = 8;
  localparam int NSL = 2;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            line_start = 1'b0;
  logic [7:0]      next_ly = '0;
  logic            tbl_rd_en;
  logic [IW-1:0]   tbl_rd_addr;
  logic [7:0]      tbl_rd_x = '0;
  logic [7:0]      tbl_rd_y = '0;
  logic            bmp_rd_en;
  logic [IW+2:0]   bmp_rd_addr;
  logic [7:0]      bmp_rd_data = '0;
  logic [NSL-1:0]  slot_valid;
  logic [8*NSL-1:0] slot_x;
  logic [8*NSL-1:0] slot_row;
  logic [IW*NSL-1:0] slot_id;
  logic            commit, busy, overflow, late;
  logic [7:0]      ovf_count;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .NUM_SLOTS(NSL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .line_start(line_start), .next_ly(next_ly),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_x(tbl_rd_x), .tbl_rd_y(tbl_rd_y),
    .bmp_rd_en(bmp_rd_en), .bmp_rd_addr(bmp_rd_addr), .bmp_rd_data(bmp_rd_data),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_row(slot_row), .slot_id(slot_id),
    .commit(commit), .busy(busy), .overflow(overflow), .late(late), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sprite attribute table and bitmap memory, 1-cycle read latency.
  logic [7:0] spr_x [NS];
  logic [7:0] spr_y [NS];
  logic [7:0] bmp   [NS*8];

  always @(posedge clk) begin
    if (tbl_rd_en) begin
      tbl_rd_x <= spr_x[tbl_rd_addr];
      tbl_rd_y <= spr_y[tbl_rd_addr];
    end
    if (bmp_rd_en) bmp_rd_data <= bmp[bmp_rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [15:0] x;
    logic [15:0] row;
    logic [5:0]  id;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic exp_t mk(string n, logic [1:0] v, logic [15:0] x, logic [15:0] r,
                              logic [5:0] id, logic ovf);
    exp_t e;
    e.name = n; e.valid = v; e.x = x; e.row = r; e.id = id; e.ovf = ovf; e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_when_idle", 64'(!busy && (tbl_rd_en || bmp_rd_en)), 64'd0);
      if (commit) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, ".valid"},   64'(slot_valid), 64'(mon_e.valid));
          check({mon_e.name, ".x"},       64'(slot_x),     64'(mon_e.x));
          check({mon_e.name, ".row"},     64'(slot_row),   64'(mon_e.row));
          check({mon_e.name, ".id"},      64'(slot_id),    64'(mon_e.id));
          check({mon_e.name, ".ovf"},     64'(overflow),   64'(mon_e.ovf));
          check({mon_e.name, ".latency"}, 64'(cyc),        64'(mon_e.cyc));
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] ly, input bit push, input exp_t e, input int lat);
    @(posedge clk); #1;
    line_start = 1'b1;
    next_ly    = ly;
    if (push) begin
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      check("commit_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic park_all();
    for (int i = 0; i < NS; i++) begin
      spr_y[i] = 8'd30;
      spr_x[i] = 8'(i * 3 + 1);
      for (int r = 0; r < 8; r++) bmp[i*8 + r] = 8'(i * 16 + r);
    end
  endtask

  typedef struct {
    logic [7:0] vy;
    logic [7:0] ly;
    logic       hit;
    logic [7:0] row;
  } vec_t;

  vec_t vecs [8];
  exp_t e_ovf;
  int   exp_cnt = 0;

  initial begin
    vecs[0] = '{vy: 8'd100, ly: 8'd107, hit: 1'b1, row: 8'h57};
    vecs[1] = '{vy: 8'd100, ly: 8'd108, hit: 1'b0, row: 8'h00};
    vecs[2] = '{vy: 8'd100, ly: 8'd99,  hit: 1'b0, row: 8'h00};
    vecs[3] = '{vy: 8'd252, ly: 8'd2,   hit: 1'b0, row: 8'h00};
    vecs[4] = '{vy: 8'd100, ly: 8'd100, hit: 1'b1, row: 8'h50};
    vecs[5] = '{vy: 8'd0,   ly: 8'd0,   hit: 1'b1, row: 8'h50};
    vecs[6] = '{vy: 8'd0,   ly: 8'd7,   hit: 1'b1, row: 8'h57};
    vecs[7] = '{vy: 8'd249, ly: 8'd255, hit: 1'b1, row: 8'h56};

    park_all();
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({tbl_rd_en, bmp_rd_en, slot_valid, slot_x, slot_row, slot_id,
               commit, busy, overflow, late, ovf_count}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single hit: sprite 3 row 2.
    spr_y[3] = 8'd10; spr_x[3] = 8'd40; bmp[3*8 + 2] = 8'hA5;
    pulse(8'd12, 1'b1, mk("single", 2'b01, {8'd0, 8'd40}, {8'd0, 8'hA5}, {3'd0, 3'd3}, 1'b0), 20);
    drain();

    // Vertical boundary vectors on sprite 5.
    park_all();
    spr_x[5] = 8'd77;
    for (int v = 0; v < 8; v++) begin
      spr_y[5] = vecs[v].vy;
      pulse(vecs[v].ly, 1'b1,
            mk($sformatf("vec%0d", v), {1'b0, vecs[v].hit},
               vecs[v].hit ? {8'd0, 8'd77} : 16'd0,
               {8'd0, vecs[v].row},
               vecs[v].hit ? {3'd0, 3'd5} : 6'd0, 1'b0),
            vecs[v].hit ? 20 : 18);
      drain();
    end

    // Overflow: sprites 1, 4, 6 all cover line 5.
    park_all();
    spr_y[1] = 8'd0; spr_y[4] = 8'd0; spr_y[6] = 8'd0;
    e_ovf = mk("overflow", 2'b11, {8'd13, 8'd4}, {8'h45, 8'h15}, {3'd4, 3'd1}, 1'b1);
    pulse(8'd5, 1'b1, e_ovf, 20);
    drain();
`ifdef SPRITE_SCHED_OVF_STATS_EN
    exp_cnt = 1;
`endif
    check("ovf_count_first", 64'(ovf_count), 64'(exp_cnt));

    // Restart while busy: only the second line commits.
    park_all();
    spr_y[3] = 8'd10; spr_y[6] = 8'd48;
    pulse(8'd12, 1'b0, e_ovf, 0);
    repeat (3) @(posedge clk);
    pulse(8'd50, 1'b1, mk("late", 2'b01, {8'd0, 8'd19}, {8'd0, 8'h62}, {3'd0, 3'd6}, 1'b0), 20);
    drain();
    check("late_sticky", 64'(late), 64'd1);

    // Disable mid-scan.
    pulse(8'd12, 1'b0, e_ovf, 0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_scan", 64'(busy), 64'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("disable_busy", 64'(busy), 64'd0);
    check("disable_valid", 64'(slot_valid), 64'd0);
    check("disable_late", 64'(late), 64'd0);
    repeat (30) @(posedge clk);
    check("disable_idle", 64'({busy, commit, slot_valid}), 64'd0);
    enable = 1'b1;
    repeat (2) @(posedge clk);

    // 256 overflowing lines saturate the counter.
    park_all();
    spr_y[1] = 8'd0; spr_y[4] = 8'd0; spr_y[6] = 8'd0;
    for (int n = 0; n < 256; n++) begin
      pulse(8'd5, 1'b1, e_ovf, 20);
      drain();
`ifdef SPRITE_SCHED_OVF_STATS_EN
      if (exp_cnt < 255) exp_cnt++;
`endif
    end
    check("ovf_count_saturate", 64'(ovf_count), 64'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler for the 256x192 logical sprite renderer.
- During horizontal blanking it scans a sprite attribute table for sprites that intersect the next logical line. It assigns the first NUM_SLOTS hits, in index order, to render slots and fetches each hit's 8-bit bitmap row.
- It then atomically publishes the slot set to the pixel datapath. This lets NUM_SPRITES sprites share NUM_SLOTS per-line render resources.

Parameters:
- NUM_SPRITES, 8, entries in the sprite table (power of 2, >=2).
- NUM_SLOTS, 2, render slots per line (1..4).
- IDX_W, $clog2(NUM_SPRITES), sprite index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  scheduler enable (stream enable)
- line_start  in  1  one-cycle pulse, early in hblank
- next_ly  in  8  logical line to prepare; sampled on line_start
- tbl_rd_en  out  1  table read strobe
- tbl_rd_addr  out  IDX_W  sprite index
- tbl_rd_x  in  8  sprite x; valid exactly 1 cycle after tbl_rd_en
- tbl_rd_y  in  8  sprite y; same timing as tbl_rd_x
- bmp_rd_en  out  1  bitmap read strobe
- bmp_rd_addr  out  IDX_W+3  {sprite index, row}
- bmp_rd_data  in  8  bitmap row, bit0 = leftmost pixel; valid 1 cycle after bmp_rd_en
- slot_valid  out  NUM_SLOTS  active slot valid bits
- slot_x  out  8*NUM_SLOTS  active slot x, slot k at [8k+7:8k]
- slot_row  out  8*NUM_SLOTS  active slot bitmap row
- slot_id  out  IDX_W*NUM_SLOTS  active slot sprite index
- commit  out  1  one-cycle pulse when the active set updates
- busy  out  1  high in any state other than IDLE
- overflow  out  1  more than NUM_SLOTS hits on the last committed line
- late  out  1  sticky; set when line_start arrives while busy; cleared by reset or disable
- ovf_count  out  8  overflow line counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE; pending and active sets cleared.
- FSM states: IDLE, SCAN_REQ, SCAN_CHK, FETCH_REQ, FETCH_WR, DONE.
- IDLE: on line_start && enable, latch next_ly, set idx=0, clear the pending set and used count, go to SCAN_REQ.
- SCAN_REQ: drive tbl_rd_en=1 with tbl_rd_addr=idx; go to SCAN_CHK.
- SCAN_CHK: compute d = {1'b0,ly} - {1'b0,y} as a 9-bit value; hit iff d[8]==0 && d<8. No vertical wrap, so y=252 never hits ly=2.
  - Hit with used<NUM_SLOTS: go to FETCH_REQ.
  - Hit with used==NUM_SLOTS: set pending overflow, go to DONE.
  - No hit: if idx==NUM_SPRITES-1 go to DONE, else idx++ and go to SCAN_REQ.
- FETCH_REQ: drive bmp_rd_en=1 with addr {idx, d[2:0]}; go to FETCH_WR.
- FETCH_WR: store x, row, idx and valid into pending slot[used]; used++. Then advance idx, or go to DONE if idx was the last sprite.
- DONE: copy pending to active (slot_*, overflow) in one cycle; pulse commit; go to IDLE.
- Slot priority: slot 0 holds the lowest hit index. Unfilled slots have valid=0, x/row/id=0.
- Worst-case latency from line_start to commit is 2*NUM_SPRITES + 2*NUM_SLOTS + 2 cycles (22 at defaults), well inside hblank.
- line_start while busy: set late and restart from IDLE semantics with the new next_ly. The active set is unchanged, with no commit for the aborted line.
- enable low: next cycle go to IDLE, clear the active set and late; outputs are 0 and no commit.
- Read strobes are never asserted in IDLE or DONE.

Optional Feature:
- Macro: SPRITE_SCHED_OVF_STATS_EN.
- With the macro: ovf_count is an 8-bit saturating counter (stops at 255), incremented at each commit with overflow=1 and cleared by reset.
- Without the macro: ovf_count is tied to 0 and no counter flops exist.

Decomposition:
- Package sprite_sched_pkg: FSM state enum, SPR_H=8, COORD_W=8, row width constant.
- Sub-module sprite_row_hit: combinational; y, ly -> hit, row[2:0]. Reused by later x-range logic.

Test Plan:
- Sprite 3 at y=10, x=40, row 2 bitmap=8'hA5; line_start, next_ly=12 -> commit after 2*8+2+2=20 cycles; slot0 valid, x=40, row=A5, id=3; slot1 invalid.
- Sprites 1, 4 and 6 all at y=0; next_ly=5 -> slots hold ids 1 and 4; overflow=1; scan stops at 6; with macro, ovf_count=1.
- Boundaries with y=100: ly=107 hits (row 7); ly=108 and ly=99 miss. With y=252, ly=2 -> no hit.
- line_start again 5 cycles after a first one -> late=1, one commit only, reflecting the second next_ly.
- Drop enable mid-scan -> busy=0 next cycle, slot_valid=0, no commit.
- Overflow on 256 consecutive lines -> ovf_count saturates at 255 (with macro); without macro it stays 0.
